bv_cfg_ctrl: RTL and testbench

- Configuration and readback controller for the bank of 9-bit bit-vector lookup stages in the bv_9_12 match pipeline.
- Accepts one host command at a time: write an entry, or read back an entry of a selected stage.
- Drives that stage's set/read port and returns the readback data or an error.
- Serialises commands so no stage ever sees set_valid or read_valid while its read sequence is in progress. Search traffic (key/bv) is untouched.

---
 rtl/bv_cfg_pkg.sv | 34 +++
 rtl/bv_cfg_ctrl_if.sv | 28 ++
 rtl/bv_cfg_rd_mux.sv | 27 ++
 rtl/bv_cfg_ctrl.sv | 158 +++++++++++++++
 tb/tb_bv_cfg_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bv_cfg_pkg.sv
// Shared constants and types for the bit-vector stage configuration controller.
package bv_cfg_pkg;

   localparam int unsigned ENTRY_ADDR_W = 9;
   localparam int unsigned ENTRY_DATA_W = 36;
   localparam int unsigned SET_W        = ENTRY_ADDR_W + ENTRY_DATA_W;

   // Field positions on the shared set_data bus
   localparam int unsigned SET_DATA_LSB = 0;
   localparam int unsigned SET_DATA_MSB = ENTRY_DATA_W - 1;
   localparam int unsigned SET_ADDR_LSB = ENTRY_DATA_W;
   localparam int unsigned SET_ADDR_MSB = SET_W - 1;

   // Cycles from a stage seeing read_valid to its data_out_valid
   localparam int unsigned STAGE_RD_LATENCY = 4;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StWr   = 3'd1,
      StRd   = 3'd2,
      StWait = 3'd3,
      StRsp  = 3'd4
   } cfg_state_e;

   function automatic logic [SET_W-1:0] pack_set(input logic [ENTRY_ADDR_W-1:0] addr,
                                                  input logic [ENTRY_DATA_W-1:0] data);
      logic [SET_W-1:0] word;
      word = '0;
      word[SET_ADDR_MSB:SET_ADDR_LSB] = addr;
      word[SET_DATA_MSB:SET_DATA_LSB] = data;
      return word;
   endfunction

endpackage

// File: rtl/bv_cfg_ctrl_if.sv
// Host command/response bus of the stage configuration controller.
interface bv_cfg_ctrl_if #(
   parameter int unsigned SEL_W = 3
);
   import bv_cfg_pkg::*;

   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_write;
   logic [SEL_W-1:0]        cmd_stage;
   logic [ENTRY_ADDR_W-1:0] cmd_addr;
   logic [ENTRY_DATA_W-1:0] cmd_data;
   logic                    rsp_valid;
   logic [ENTRY_DATA_W-1:0] rsp_data;
   logic                    rsp_error;
   logic                    busy;

   modport master (
      output cmd_valid, cmd_write, cmd_stage, cmd_addr, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_error, busy
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_stage, cmd_addr, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_error, busy
   );

endinterface

// File: rtl/bv_cfg_rd_mux.sv
// Selects one stage's readback valid and data slice by stage index.
module bv_cfg_rd_mux
   import bv_cfg_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned SEL_W      = 3
) (
   input  logic [SEL_W-1:0]                       sel_i,
   input  logic [NUM_STAGES-1:0]                  valid_i,
   input  logic [ENTRY_DATA_W*NUM_STAGES-1:0]     data_i,
   output logic                                   valid_o,
   output logic [ENTRY_DATA_W-1:0]                data_o
);

   // Out-of-range index yields no valid and zero data
   always_comb begin
      valid_o = 1'b0;
      data_o  = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (sel_i == SEL_W'(i)) begin
            valid_o = valid_i[i];
            data_o  = data_i[ENTRY_DATA_W*i +: ENTRY_DATA_W];
         end
      end
   end

endmodule

// File: rtl/bv_cfg_ctrl.sv
// Serialises host write/readback commands onto the lookup stages' set/read ports.
module bv_cfg_ctrl
   import bv_cfg_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned SEL_W      = 3,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                               clk,
   input  logic                               reset,
   bv_cfg_ctrl_if.slave                       host,
   output logic [NUM_STAGES-1:0]              set_valid,
   output logic [SET_W-1:0]                   set_data,
   output logic [NUM_STAGES-1:0]              read_valid,
   output logic [ENTRY_ADDR_W-1:0]            read_addr,
   input  logic [NUM_STAGES-1:0]              stage_rd_valid,
   input  logic [ENTRY_DATA_W*NUM_STAGES-1:0] stage_rd_data
);

   cfg_state_e              state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [SEL_W-1:0]        stage_q, stage_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    busy_q, busy_d;
   logic [NUM_STAGES-1:0]   set_valid_q, set_valid_d;
   logic [SET_W-1:0]        set_data_q, set_data_d;
   logic [NUM_STAGES-1:0]   read_valid_q, read_valid_d;
   logic [ENTRY_ADDR_W-1:0] read_addr_q, read_addr_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [ENTRY_DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic                    rsp_error_q, rsp_error_d;

   logic                    sel_valid;
   logic [ENTRY_DATA_W-1:0] sel_data;
   logic                    accept;
   logic                    stage_ok;
   logic [NUM_STAGES-1:0]   cmd_onehot;

   assign accept     = host.cmd_valid && cmd_ready_q;
   assign stage_ok   = 32'(host.cmd_stage) < NUM_STAGES;
   assign cmd_onehot = NUM_STAGES'(1) << host.cmd_stage;

   bv_cfg_rd_mux #(
      .NUM_STAGES (NUM_STAGES),
      .SEL_W      (SEL_W)
   ) u_rd_mux (
      .sel_i   (stage_q),
      .valid_i (stage_rd_valid),
      .data_i  (stage_rd_data),
      .valid_o (sel_valid),
      .data_o  (sel_data)
   );

   // Next state; all outputs are registered on entry to the state that owns them
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stage_d      = stage_q;
      set_data_d   = set_data_q;
      read_addr_d  = read_addr_q;
      set_valid_d  = '0;
      read_valid_d = '0;
      rsp_valid_d  = 1'b0;
      rsp_data_d   = rsp_data_q;
      rsp_error_d  = rsp_error_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               stage_d = host.cmd_stage;
               if (!stage_ok) begin
                  state_d     = StRsp;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
                  rsp_data_d  = '0;
               end else if (host.cmd_write) begin
                  state_d     = StWr;
                  set_valid_d = cmd_onehot;
                  set_data_d  = pack_set(host.cmd_addr, host.cmd_data);
               end else begin
                  state_d      = StRd;
                  read_valid_d = cmd_onehot;
                  read_addr_d  = host.cmd_addr;
               end
            end
         end
         StWr: state_d = StIdle;
         StRd: begin
            state_d = StWait;
            cnt_d   = '0;
         end
         StWait: begin
            // A valid arriving on the last allowed cycle beats the timeout
            if (sel_valid) begin
               state_d     = StRsp;
               rsp_valid_d = 1'b1;
               rsp_data_d  = sel_data;
               rsp_error_d = 1'b0;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d     = StRsp;
               cnt_d       = 8'(TIMEOUT);
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StRsp:   state_d = StIdle;
         default: state_d = StIdle;
      endcase

      cmd_ready_d = (state_d == StIdle);
      busy_d      = (state_d != StIdle);
   end

   // State and output registers; reset abandons any command without a response
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         stage_q      <= '0;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         set_valid_q  <= '0;
         set_data_q   <= '0;
         read_valid_q <= '0;
         read_addr_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         stage_q      <= stage_d;
         cmd_ready_q  <= cmd_ready_d;
         busy_q       <= busy_d;
         set_valid_q  <= set_valid_d;
         set_data_q   <= set_data_d;
         read_valid_q <= read_valid_d;
         read_addr_q  <= read_addr_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_error_q  <= rsp_error_d;
      end
   end

   assign host.cmd_ready = cmd_ready_q;
   assign host.busy      = busy_q;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_data  = rsp_data_q;
   assign host.rsp_error = rsp_error_q;
   assign set_valid      = set_valid_q;
   assign set_data       = set_data_q;
   assign read_valid     = read_valid_q;
   assign read_addr      = read_addr_q;

endmodule

// File: tb/tb_bv_cfg_ctrl.sv
// Randomised bench for bv_cfg_ctrl with a per-stage entry memory and latency model.
module tb_bv_cfg_ctrl;
   import bv_cfg_pkg::*;

   localparam int unsigned NUM_STAGES = 4;
   localparam int unsigned SEL_W      = 3;
   localparam int unsigned TIMEOUT    = 6;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   bv_cfg_ctrl_if #(.SEL_W(SEL_W)) host_if ();

   logic [NUM_STAGES-1:0]              set_valid;
   logic [SET_W-1:0]                   set_data;
   logic [NUM_STAGES-1:0]              read_valid;
   logic [ENTRY_ADDR_W-1:0]            read_addr;
   logic [NUM_STAGES-1:0]              stage_rd_valid;
   logic [ENTRY_DATA_W*NUM_STAGES-1:0] stage_rd_data;

   bv_cfg_ctrl #(
      .NUM_STAGES (NUM_STAGES),
      .SEL_W      (SEL_W),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .host           (host_if.slave),
      .set_valid      (set_valid),
      .set_data       (set_data),
      .read_valid     (read_valid),
      .read_addr      (read_addr),
      .stage_rd_valid (stage_rd_valid),
      .stage_rd_data  (stage_rd_data)
   );

   int total = 0;
   int bad   = 0;

   // Contents every stage would hold after the writes issued so far
   logic [ENTRY_DATA_W-1:0] mem [NUM_STAGES][512];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ENTRY_DATA_W-1:0] rnd36();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[ENTRY_DATA_W-1:0];
   endfunction

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_cmd_ready"}, 64'(host_if.cmd_ready), 64'd1);
      check_eq({tag, "_busy"}, 64'(host_if.busy), 64'd0);
      check_eq({tag, "_set_valid"}, 64'(set_valid), 64'd0);
      check_eq({tag, "_read_valid"}, 64'(read_valid), 64'd0);
      check_eq({tag, "_rsp_valid"}, 64'(host_if.rsp_valid), 64'd0);
   endtask

   // One command; lat = cycles from read_valid to the stage's valid, 0 = stage stays silent.
   // Cycle n is the n-th cycle after the accepting edge.
   task automatic do_cmd(input bit wr, input int stage, input logic [8:0] addr,
                         input logic [35:0] data, input int lat);
      bit                    bad_stage;
      int                    tgt, spur, rsp_cyc, done_cyc, guard;
      bit                    exp_err;
      logic [35:0]           exp_data;
      logic [NUM_STAGES-1:0] onehot;

      bad_stage = (stage >= NUM_STAGES);
      tgt       = bad_stage ? 0 : stage;
      spur      = (tgt + 1) % NUM_STAGES;
      onehot    = bad_stage ? '0 : NUM_STAGES'(1) << stage;
      exp_err   = 1'b0;
      exp_data  = '0;
      rsp_cyc   = -1;
      if (bad_stage) begin
         rsp_cyc  = 1;
         exp_err  = 1'b1;
         done_cyc = 2;
      end else if (wr) begin
         done_cyc = 2;
      end else if (lat >= 1 && lat <= TIMEOUT) begin
         rsp_cyc  = lat + 2;
         exp_data = mem[tgt][addr];
         done_cyc = rsp_cyc + 1;
      end else begin
         rsp_cyc  = TIMEOUT + 2;
         exp_err  = 1'b1;
         done_cyc = rsp_cyc + 1;
      end

      guard = 0;
      while (host_if.cmd_ready !== 1'b1 && guard < 50) begin
         step();
         guard++;
      end
      check_eq("ready_before_cmd", 64'(host_if.cmd_ready), 64'd1);

      host_if.cmd_valid = 1'b1;
      host_if.cmd_write = wr;
      host_if.cmd_stage = SEL_W'(stage);
      host_if.cmd_addr  = addr;
      host_if.cmd_data  = data;
      step();
      if (wr && !bad_stage) mem[tgt][addr] = data;

      for (int n = 1; n <= done_cyc; n++) begin
         // Host keeps poking while busy; those commands must be ignored
         if (n < done_cyc) begin
            host_if.cmd_valid = 1'($urandom_range(0, 1));
            host_if.cmd_write = 1'($urandom_range(0, 1));
            host_if.cmd_stage = SEL_W'($urandom_range(0, 7));
            host_if.cmd_addr  = 9'($urandom);
            host_if.cmd_data  = rnd36();
         end else begin
            host_if.cmd_valid = 1'b0;
         end
         for (int i = 0; i < NUM_STAGES; i++) begin
            stage_rd_data[ENTRY_DATA_W*i +: ENTRY_DATA_W] = rnd36();
            if (!bad_stage && !wr && i == tgt) begin
               stage_rd_valid[i] = (lat > 0 && n == lat + 1);
               if (n == lat + 1) stage_rd_data[ENTRY_DATA_W*i +: ENTRY_DATA_W] = mem[tgt][addr];
            end else if (i == spur && n == 2) begin
               stage_rd_valid[i] = 1'b1;
            end else begin
               stage_rd_valid[i] = 1'($urandom_range(0, 1));
            end
         end

         check_eq("set_valid", 64'(set_valid), (wr && !bad_stage && n == 1) ? 64'(onehot) : 64'd0);
         check_eq("read_valid", 64'(read_valid),
                  (!wr && !bad_stage && n == 1) ? 64'(onehot) : 64'd0);
         if (n == 1 && wr && !bad_stage) check_eq("set_data", 64'(set_data), 64'({addr, data}));
         if (n == 1 && !wr && !bad_stage) check_eq("read_addr", 64'(read_addr), 64'(addr));
         check_eq("rsp_valid", 64'(host_if.rsp_valid), 64'(n == rsp_cyc));
         if (n == rsp_cyc) begin
            check_eq("rsp_error", 64'(host_if.rsp_error), 64'(exp_err));
            check_eq("rsp_data", 64'(host_if.rsp_data), 64'(exp_data));
         end
         check_eq("cmd_ready", 64'(host_if.cmd_ready), 64'(n == done_cyc));
         check_eq("busy", 64'(host_if.busy), 64'(n != done_cyc));
         if (n < done_cyc) step();
      end
   endtask

   initial begin
      int lat;
      for (int s = 0; s < NUM_STAGES; s++) begin
         for (int a = 0; a < 512; a++) mem[s][a] = '0;
      end
      host_if.cmd_valid = 1'b0;
      host_if.cmd_write = 1'b0;
      host_if.cmd_stage = '0;
      host_if.cmd_addr  = '0;
      host_if.cmd_data  = '0;
      stage_rd_valid    = '0;
      stage_rd_data     = '0;

      step();
      check_idle_outputs("reset");
      check_eq("reset_rsp_data", 64'(host_if.rsp_data), 64'd0);
      check_eq("reset_rsp_error", 64'(host_if.rsp_error), 64'd0);
      step();
      @(negedge clk) reset = 1'b1;
      step();

      // Directed cases
      do_cmd(1'b1, 2, 9'h1A5, 36'h123456789, 0);
      do_cmd(1'b1, 1, 9'h0FF, 36'hFEDCBA987, 0);
      do_cmd(1'b0, 1, 9'h0FF, 36'h0, STAGE_RD_LATENCY);
      do_cmd(1'b0, 3, 9'h010, 36'h0, 0);
      do_cmd(1'b0, 5, 9'h0FF, 36'h0, STAGE_RD_LATENCY);
      do_cmd(1'b1, 6, 9'h0FF, 36'hABCDE0123, 0);
      do_cmd(1'b0, 1, 9'h0FF, 36'h0, TIMEOUT);
      do_cmd(1'b0, 1, 9'h0FF, 36'h0, TIMEOUT + 1);

      // Reset while waiting on a stage: pending read dropped, no response afterwards
      host_if.cmd_valid = 1'b1;
      host_if.cmd_write = 1'b0;
      host_if.cmd_stage = SEL_W'(1);
      host_if.cmd_addr  = 9'h0FF;
      step();
      host_if.cmd_valid = 1'b0;
      step();
      step();
      check_eq("wait_busy", 64'(host_if.busy), 64'd1);
      reset = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      check_eq("mid_reset_rsp_data", 64'(host_if.rsp_data), 64'd0);
      check_eq("mid_reset_rsp_error", 64'(host_if.rsp_error), 64'd0);
      stage_rd_valid = '1;
      step();
      @(negedge clk) reset = 1'b1;
      for (int n = 0; n < int'(TIMEOUT) + 4; n++) begin
         step();
         check_idle_outputs("post_reset");
      end
      stage_rd_valid = '0;
      do_cmd(1'b0, 2, 9'h1A5, 36'h0, STAGE_RD_LATENCY);

      // Random traffic over a small address window so reads hit earlier writes
      for (int k = 0; k < 80; k++) begin
         lat = $urandom_range(0, TIMEOUT + 2);
         do_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 5), 9'($urandom_range(0, 15)),
                rnd36(), lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
